data_mem_responder: RTL and testbench

- Responder side of the core's load/store data-memory interface: accepts one request at a time from the PROCESSOR load/store path and returns read data or a store acknowledgement.
- Holds a synchronous doubleword-organised RAM with byte-lane store merging and load sign/zero extension.
- Inserts a programmable number of wait states, so the core's stall logic can be exercised against non-zero memory latency.
- Sits beside the core in the processor top level.

---
 rtl/data_mem_responder_pkg.sv | 19 +
 rtl/dmem_lane_align.sv | 37 +++
 rtl/data_mem_responder.sv | 137 +++++++++++++
 tb/tb_data_mem_responder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: size and FSM state encodings plus the wait-counter width for the data-memory responder
package data_mem_responder_pkg;

   localparam int LAT_W = 4;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_D = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_WAIT = 2'b01,
      S_RESP = 2'b10
   } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane store shift and enables, load extract with sign/zero extension, misalignment detection
module dmem_lane_align
   import data_mem_responder_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [2:0]      addr_lo_i,
   input  logic [1:0]      size_i,
   input  logic            unsigned_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [XLEN-1:0] rword_i,
   output logic [XLEN-1:0] wlanes_o,
   output logic [7:0]      be_o,
   output logic [XLEN-1:0] rdata_o,
   output logic            misaligned_o
);

   logic [5:0]      sh;
   logic [7:0]      mask;
   logic [XLEN-1:0] rsh;

   // Lanes start at the byte offset; the access must sit on a multiple of its own size
   always_comb begin
      sh           = {addr_lo_i, 3'b000};
      mask         = size_i == SZ_B ? 8'h01 : size_i == SZ_H ? 8'h03 : size_i == SZ_W ? 8'h0f : 8'hff;
      be_o         = mask << addr_lo_i;
      wlanes_o     = wdata_i << sh;
      rsh          = rword_i >> sh;
      misaligned_o = size_i == SZ_H ? addr_lo_i[0] :
                     size_i == SZ_W ? |addr_lo_i[1:0] :
                     size_i == SZ_D ? |addr_lo_i : 1'b0;
      rdata_o      = size_i == SZ_B ? {{(XLEN-8){~unsigned_i & rsh[7]}}, rsh[7:0]} :
                     size_i == SZ_H ? {{(XLEN-16){~unsigned_i & rsh[15]}}, rsh[15:0]} :
                     size_i == SZ_W ? {{(XLEN-32){~unsigned_i & rsh[31]}}, rsh[31:0]} : rsh;
   end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store responder with wait states over a doubleword RAM
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_error
);
  localparam int              AW      = $clog2(DEPTH);
  localparam logic [XLEN-4:0] DEPTH_V = (XLEN-3)'(DEPTH);
  state_e            state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, uns_q;
  logic [1:0]        size_q;
  logic [XLEN-1:0]   addr_q, wdata_q;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              error_q, error_d;
  logic              accept, enter;
  logic              cur_write, cur_uns;
  logic [1:0]        cur_size;
  logic [XLEN-1:0]   cur_addr, cur_wdata;
  logic [AW-1:0]     idx;
  logic [XLEN-1:0]   rword, wlanes, ext;
  logic [7:0]        be;
  logic              misaligned, err;
  logic [XLEN-1:0]   ram [DEPTH];

  assign req_ready = state_q == S_IDLE && !reset;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = state_q == S_RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;

  always_comb begin
    cur_write = state_q == S_IDLE ? req_write : write_q;
    cur_uns   = state_q == S_IDLE ? req_unsigned : uns_q;
    cur_size  = state_q == S_IDLE ? req_size : size_q;
    cur_addr  = state_q == S_IDLE ? req_addr : addr_q;
    cur_wdata = state_q == S_IDLE ? req_wdata : wdata_q;
    idx       = cur_addr[AW+2:3];
    rword     = ram[idx];
    err       = misaligned || cur_addr[XLEN-1:3] >= DEPTH_V;
  end

  dmem_lane_align #(.XLEN(XLEN)) u_align (
    .addr_lo_i    (cur_addr[2:0]),
    .size_i       (cur_size),
    .unsigned_i   (cur_uns),
    .wdata_i      (cur_wdata),
    .rword_i      (rword),
    .wlanes_o     (wlanes),
    .be_o         (be),
    .rdata_o      (ext),
    .misaligned_o (misaligned)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    enter   = 1'b0;
    rdata_d = rdata_q;
    error_d = error_q;
    unique case (state_q)
      S_IDLE: if (accept) begin
        if (LATENCY == 0) begin
          state_d = S_RESP;
          enter   = 1'b1;
        end else begin
          state_d = S_WAIT;
          cnt_d   = LAT_W'(LATENCY - 1);
        end
      end
      S_WAIT: if (cnt_q == '0) begin
        state_d = S_RESP;
        enter   = 1'b1;
      end else begin
        cnt_d = cnt_q - LAT_W'(1);
      end
      S_RESP: if (rsp_ready) begin
        state_d = S_IDLE;
        rdata_d = '0;
        error_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    if (enter) begin
      error_d = err;
      rdata_d = err || cur_write ? '0 : ext;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      write_q <= req_write;
      uns_q   <= req_unsigned;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (enter && cur_write && !err && !reset) begin
      for (int i = 0; i < 8; i++) begin
        if (be[i]) ram[idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized and directed checks of data_mem_responder against a byte-array reference model
module tb_data_mem_responder;

   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic [2:0]  rst_v, valid_v, rdy_v, req_ready_v, rsp_valid_v, rsp_error_v;
   logic [63:0] rdata_v [3];
   logic        wr, uns;
   logic [1:0]  size;
   logic [63:0] addr, wdata;
   int          n_chk = 0;
   int          n_pass = 0;
   logic [7:0]  mem [3][DEPTH*8];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      data_mem_responder #(
         .XLEN(64), .DEPTH(DEPTH), .LATENCY(g == 0 ? 2 : g == 1 ? 4 : 0)
      ) dut (
         .clock        (clk),
         .reset        (rst_v[g]),
         .req_valid    (valid_v[g]),
         .req_ready    (req_ready_v[g]),
         .req_write    (wr),
         .req_addr     (addr),
         .req_wdata    (wdata),
         .req_size     (size),
         .req_unsigned (uns),
         .rsp_valid    (rsp_valid_v[g]),
         .rsp_ready    (rdy_v[g]),
         .rsp_rdata    (rdata_v[g]),
         .rsp_error    (rsp_error_v[g])
      );
   end

   function automatic int lat_of(input int u);
      return u == 0 ? 2 : u == 1 ? 4 : 0;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic model(input int u, input logic w, input logic [63:0] a, input logic [1:0] sz,
                        input logic [63:0] wd, input logic un, output logic [63:0] erd, output logic eerr);
      int n;
      n    = 1 << sz;
      erd  = '0;
      eerr = (a % 64'(n) != 0) || (a >= 64'(DEPTH*8));
      if (eerr) return;
      if (w) begin
         for (int i = 0; i < n; i++) mem[u][int'(a) + i] = wd[8*i +: 8];
      end else begin
         for (int i = 0; i < n; i++) erd[8*i +: 8] = mem[u][int'(a) + i];
         if (!un && n < 8 && erd[8*n-1]) erd = erd | ~((64'd1 << (8*n)) - 64'd1);
      end
   endtask

   task automatic xact(input int u, input logic w, input logic [63:0] a, input logic [1:0] sz,
                       input logic [63:0] wd, input logic un, input int hold,
                       output logic [63:0] got, output logic gerr);
      logic [63:0] erd;
      logic        eerr;
      int          k;
      bit          busy_ok;
      @(negedge clk);
      wr = w; addr = a; size = sz; wdata = wd; uns = un;
      valid_v[u] = 1'b1;
      rdy_v[u]   = hold == 0;
      check("req_ready", req_ready_v[u], 1);
      @(posedge clk);
      #1;
      valid_v[u] = 1'b0;
      wr = ~w; addr = {$urandom, $urandom}; size = 2'($urandom); wdata = {$urandom, $urandom}; uns = ~un;
      model(u, w, a, sz, wd, un, erd, eerr);
      k = 0;
      busy_ok = 1'b1;
      do begin
         @(negedge clk);
         k++;
         if (req_ready_v[u]) busy_ok = 1'b0;
      end while (!rsp_valid_v[u] && k < 40);
      check("latency", k, lat_of(u) + 1);
      got  = rdata_v[u];
      gerr = rsp_error_v[u];
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (!rsp_valid_v[u] || rdata_v[u] !== got || rsp_error_v[u] !== gerr || req_ready_v[u]) busy_ok = 1'b0;
         addr = {$urandom, $urandom};
         valid_v[u] = (i % 2 == 0) && (i < hold - 1);
      end
      valid_v[u] = 1'b0;
      rdy_v[u]   = 1'b1;
      check("busy_stable", busy_ok, 1);
      check("rdata", got, erd);
      check("error", gerr, eerr);
      @(negedge clk);
      check("idle", {rsp_valid_v[u], req_ready_v[u]}, 2'b01);
      check("cleared", rdata_v[u] | 64'(rsp_error_v[u]), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [63:0] got, a;
      logic        ge;
      bit          quiet;
      rst_v = '1; valid_v = '0; rdy_v = '1;
      wr = 0; addr = 0; size = 0; wdata = 0; uns = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", req_ready_v, 0);
      check("rst_valid", rsp_valid_v, 0);
      check("rst_rdata", rdata_v[0], 0);
      check("rst_error", rsp_error_v, 0);
      rst_v = '0;
      @(negedge clk);
      check("post_rst_ready", req_ready_v, 3'b111);

      xact(0, 1, 64'h10, 2'b11, 64'h0123456789ABCDEF, 0, 0, got, ge);
      check("t1_rdata", got, 0);
      check("t1_error", ge, 0);
      xact(0, 0, 64'h10, 2'b00, 0, 0, 0, got, ge);
      check("t2_sbyte", got, 64'hFFFFFFFFFFFFFFEF);
      xact(0, 0, 64'h10, 2'b00, 0, 1, 0, got, ge);
      check("t2_ubyte", got, 64'h00000000000000EF);
      xact(0, 0, 64'h17, 2'b00, 0, 0, 0, got, ge);
      check("t2_sbyte17", got, 64'h0000000000000001);
      xact(0, 1, 64'h12, 2'b01, 64'hBEEF, 0, 0, got, ge);
      xact(0, 0, 64'h10, 2'b11, 0, 0, 0, got, ge);
      check("t3_dword", got, 64'h01234567BEEFCDEF);
      xact(0, 0, 64'h12, 2'b01, 0, 0, 0, got, ge);
      check("t3_shalf", got, 64'hFFFFFFFFFFFFBEEF);
      xact(0, 0, 64'h13, 2'b10, 0, 0, 0, got, ge);
      check("t4_mis_err", ge, 1);
      check("t4_mis_rdata", got, 0);
      xact(0, 1, 64'(DEPTH*8), 2'b11, 64'hDEADBEEFDEADBEEF, 0, 0, got, ge);
      check("t4_oor_err", ge, 1);
      xact(0, 0, 64'h10, 2'b11, 0, 0, 0, got, ge);
      check("t4_reload", got, 64'h01234567BEEFCDEF);

      xact(0, 0, 64'h10, 2'b11, 0, 0, 5, got, ge);
      check("t5_rdata", got, 64'h01234567BEEFCDEF);
      quiet = 1'b1;
      repeat (lat_of(0) + 2) begin
         @(negedge clk);
         if (rsp_valid_v[0]) quiet = 1'b0;
      end
      check("t5_no_second", quiet, 1);

      for (int d = 0; d < 16; d++) xact(0, 1, 64'(d * 8), 2'b11, {$urandom, $urandom}, 0, 0, got, ge);
      xact(0, 1, 64'(DEPTH*8 - 8), 2'b11, {$urandom, $urandom}, 0, 0, got, ge);
      for (int t = 0; t < 120; t++) begin
         int r;
         r = $urandom_range(0, 9);
         a = r == 0 ? 64'(DEPTH*8 + $urandom_range(0, 15)) :
             r == 1 ? 64'(DEPTH*8 - 8 + $urandom_range(0, 7)) : 64'($urandom_range(0, 127));
         xact(0, 1'($urandom), a, 2'($urandom), {$urandom, $urandom}, 1'($urandom),
              $urandom_range(0, 3), got, ge);
      end

      xact(1, 1, 64'h10, 2'b11, 64'h1122334455667788, 0, 0, got, ge);
      @(negedge clk);
      wr = 1; addr = 64'h10; size = 2'b11; wdata = '1; uns = 0;
      valid_v[1] = 1'b1;
      @(posedge clk);
      #1;
      valid_v[1] = 1'b0;
      @(negedge clk);
      check("t6_wait", rsp_valid_v[1], 0);
      rst_v[1] = 1'b1;
      @(negedge clk);
      check("t6_rst_ready", req_ready_v[1], 0);
      rst_v[1] = 1'b0;
      quiet = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (rsp_valid_v[1]) quiet = 1'b0;
      end
      check("t6_no_resp", quiet, 1);
      xact(1, 0, 64'h10, 2'b11, 0, 0, 0, got, ge);
      check("t6_prior", got, 64'h1122334455667788);

      xact(2, 1, 64'h10, 2'b11, 64'h0123456789ABCDEF, 0, 0, got, ge);
      check("t6_lat0_error", ge, 0);
      xact(2, 0, 64'h10, 2'b11, 0, 0, 0, got, ge);
      check("t6_lat0_dword", got, 64'h0123456789ABCDEF);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
